risc8_data_arbiter: RTL
=======================

// Module: risc8_data_arbiter
// PURPOSE
//  Shares the single-port data RAM between the risc8 core and one DMA requester.
//  The core has priority. A saturating starvation counter forces a DMA grant and
//  stalls the core once the DMA has waited STARVE_LIMIT cycles.
//  The block sits between the core data bus and risc8_ram. IO decode stays outside.
// PARAMETERS
//  IO_TOP       16'h0060  addresses below this are IO; they never touch RAM
//  STARVE_LIMIT 4         DMA wait cycles before a forced grant; 0 = DMA strict priority
//  STAT_BITS    16        width of the statistics counters
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-low reset
//  core_addr    in   16  core data address
//  core_wen     in   1   core write strobe
//  core_ren     in   1   core read strobe
//  core_wdata   in   8   core write data
//  core_rdata   out  8   RAM read data to core (1-cycle latency)
//  core_stall   out  1   core must hold its access this cycle (combinational)
//  dma_req      in   1   DMA access request; held until dma_gnt
//  dma_we       in   1   1 = write, 0 = read; held with dma_req
//  dma_addr     in   16  DMA address; held with dma_req
//  dma_wdata    in   8   DMA write data; held with dma_req
//  dma_gnt      out  1   one-cycle accept of the DMA request (combinational)
//  dma_err      out  1   registered pulse: the accepted request targeted IO space
//  dma_rvalid   out  1   registered pulse: dma_rdata valid for a granted read
//  dma_rdata    out  8   RAM read data to DMA
//  ram_addr     out  16  to risc8_ram addr
//  ram_wen      out  1   to risc8_ram wen
//  ram_wdata    out  8   to risc8_ram wdata
//  ram_rdata    in   8   from risc8_ram rdata; registered RAM, 1-cycle latency
//  stat_dma     out  STAT_BITS  count of granted DMA RAM accesses
//  stat_stall   out  STAT_BITS  count of core stall cycles
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): starve_cnt, dma_rvalid, dma_err, owner_q and stats
//    clear to 0. An in-flight read's dma_rvalid is suppressed.
//  - Definitions:
//    core_ram = (core_wen|core_ren) & (core_addr < IO_TOP) == 0
//    dma_io   = dma_addr < IO_TOP
//    force    = dma_req & (starve_cnt == STARVE_LIMIT)
//  - Grant, evaluated each cycle in this order:
//    1. dma_req & dma_io: dma_gnt=1, no RAM access, dma_err=1 next cycle.
//       The core proceeds unaffected.
//    2. force & core_ram: DMA owns RAM, dma_gnt=1, core_stall=1.
//    3. core_ram: core owns RAM, dma_gnt=0.
//    4. dma_req: DMA owns RAM, dma_gnt=1. Core IO accesses run in parallel.
//    5. Otherwise: ram_wen=0 and ram_addr=core_addr.
//  - RAM mux: the owner drives ram_addr and ram_wdata. ram_wen = owner's write strobe.
//  - Read return:
//    - owner_q <= DMA-read-granted.
//    - dma_rvalid <= owner_q next cycle; dma_rdata = ram_rdata.
//    - core_rdata = ram_rdata always.
//  - starve_cnt:
//    - Cleared on dma_gnt or !dma_req.
//    - Else incremented, saturating at STARVE_LIMIT.
//    - Hence at most STARVE_LIMIT+1 wait cycles.
//  - core_stall only asserts when case 2 applies. The stalled core retries next
//    cycle and wins, because starve_cnt is now 0.
//  - Simultaneous core write and DMA write: exactly one reaches RAM per cycle;
//    the loser is neither granted nor dropped.
// CONFIGURATION
//  RISC8_ARB_STATS_EN defined:
//    - stat_dma increments on each case-2/4 grant.
//    - stat_stall increments on each core_stall cycle.
//    - Both wrap modulo 2^STAT_BITS and clear on reset.
//  Undefined: stat_dma and stat_stall are constant 0 and no counter flops exist.
// TESTING
//  1. Idle core. DMA write 0xA5 to 0x0100, then DMA read 0x0100
//     -> dma_gnt same cycle each; dma_rvalid 1 cycle after the read grant; dma_rdata=0xA5.
//  2. Core reads 0x0200 every cycle, dma_req held, STARVE_LIMIT=4
//     -> dma_gnt in the 5th request cycle; core_stall=1 for exactly that cycle;
//        the core read completes the next cycle.
//  3. DMA read of 0x0040
//     -> dma_gnt=1, ram_wen=0, dma_err=1 next cycle, dma_rvalid stays 0.
//  4. Core writes IO 0x0038 while DMA writes 0x0300=0x5A
//     -> dma_gnt same cycle, no core_stall, RAM[0x0300]=0x5A.
//  5. Reset low the cycle after a DMA read grant
//     -> dma_rvalid stays 0; starve_cnt and stats read 0 after release.
//  6. With RISC8_ARB_STATS_EN, run scenario 2 twice
//     -> stat_dma=2, stat_stall=2. Without it, both read 0.

Source files
------------

// File: rtl/risc8_data_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : risc8_data_arbiter
//  Description : Shares the single-port data RAM between the risc8 core and a
//                DMA requester. The core has priority and a starvation counter
//                forces a DMA grant. Optional statistics counters are built only
//                when RISC8_ARB_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module risc8_data_arbiter #(
    parameter logic [15:0] IO_TOP       = 16'h0060,
    parameter int          STARVE_LIMIT = 4,
    parameter int          STAT_BITS    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          core_addr,
    input  logic                 core_wen,
    input  logic                 core_ren,
    input  logic [7:0]           core_wdata,
    output logic [7:0]           core_rdata,
    output logic                 core_stall,
    input  logic                 dma_req,
    input  logic                 dma_we,
    input  logic [15:0]          dma_addr,
    input  logic [7:0]           dma_wdata,
    output logic                 dma_gnt,
    output logic                 dma_err,
    output logic                 dma_rvalid,
    output logic [7:0]           dma_rdata,
    output logic [15:0]          ram_addr,
    output logic                 ram_wen,
    output logic [7:0]           ram_wdata,
    input  logic [7:0]           ram_rdata,
    output logic [STAT_BITS-1:0] stat_dma,
    output logic [STAT_BITS-1:0] stat_stall
);

    localparam int c_CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    logic [c_CNT_W-1:0] r_starve_cnt;
    logic               r_owner_q;
    logic               r_dma_err;
    logic               w_core_ram;
    logic               w_dma_io;
    logic               w_force;
    logic               w_dma_io_gnt;
    logic               w_dma_owns;

    assign w_core_ram = (core_wen | core_ren) & (core_addr >= IO_TOP);
    assign w_dma_io   = dma_addr < IO_TOP;
    assign w_force    = dma_req & (r_starve_cnt == c_LIMIT);

    // Priority: DMA IO reject, forced DMA, core, opportunistic DMA.
    always_comb begin
        w_dma_io_gnt = 1'b0;
        w_dma_owns   = 1'b0;
        core_stall   = 1'b0;
        if (dma_req & w_dma_io) begin
            w_dma_io_gnt = 1'b1;
        end else if (w_force & w_core_ram) begin
            w_dma_owns = 1'b1;
            core_stall = 1'b1;
        end else if (w_core_ram) begin
            w_dma_owns = 1'b0;
        end else if (dma_req) begin
            w_dma_owns = 1'b1;
        end
    end

    assign dma_gnt = w_dma_io_gnt | w_dma_owns;

    always_comb begin
        ram_addr  = core_addr;
        ram_wdata = core_wdata;
        ram_wen   = 1'b0;
        if (w_dma_owns) begin
            ram_addr  = dma_addr;
            ram_wdata = dma_wdata;
            ram_wen   = dma_we;
        end else if (w_core_ram) begin
            ram_wen   = core_wen;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_starve_cnt <= '0;
            r_owner_q    <= 1'b0;
            r_dma_err    <= 1'b0;
        end else begin
            r_owner_q <= w_dma_owns & ~dma_we;
            r_dma_err <= w_dma_io_gnt;
            if (!dma_req || dma_gnt) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != c_LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    // Gating with reset drops a read return that is in flight when reset arrives.
    assign dma_rvalid = r_owner_q & reset;
    assign dma_err    = r_dma_err;
    assign dma_rdata  = ram_rdata;
    assign core_rdata = ram_rdata;

`ifdef RISC8_ARB_STATS_EN
    logic [STAT_BITS-1:0] r_stat_dma;
    logic [STAT_BITS-1:0] r_stat_stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stat_dma   <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_dma_owns) r_stat_dma   <= r_stat_dma + 1'b1;
            if (core_stall) r_stat_stall <= r_stat_stall + 1'b1;
        end
    end

    assign stat_dma   = r_stat_dma;
    assign stat_stall = r_stat_stall;
`else
    assign stat_dma   = '0;
    assign stat_stall = '0;
`endif

endmodule
`default_nettype wire
